// File: rtl/round_scorer.sv
// Round scorer: runs one guessing round per accepted start, then hands the
// player and score to the score tracker and holds them stable while it writes.
module round_scorer #(
  parameter int MAX_GUESSES = 7,
  parameter int HOLDOFF     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] player_in,
  input  logic       guess_valid,
  input  logic       guess_correct,
  input  logic       abort,
  output logic [2:0] playerID,
  output logic [2:0] newScore,
  output logic       enable,
  output logic       round_active,
  output logic       busy,
  output logic [2:0] guess_count
);

  typedef enum logic [1:0] {IDLE, PLAY, REPORT, HOLD} state_t;

  localparam logic [2:0] MAX_G     = 3'(MAX_GUESSES);
  localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF - 1);
  localparam logic [2:0] MAX_PLYR  = 3'd4;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] player_q, player_d;
  logic [2:0] score_q, score_d;
  logic [2:0] count_q, count_d;
  logic       enable_q, enable_d;
  logic       active_q, active_d;
  logic       busy_q, busy_d;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    player_d = player_q;
    score_d  = score_q;
    count_d  = count_q;
    enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (player_in <= MAX_PLYR)) begin
          player_d = player_in;
          score_d  = 3'd0;
          count_d  = 3'd0;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        // abort wins over a guess arriving in the same cycle
        if (abort) begin
          state_d = IDLE;
        end else if (guess_valid) begin
          count_d = count_q + 3'd1;
          if (guess_correct) score_d = sat_inc(score_q);
          if (!guess_correct || (count_d == MAX_G)) begin
            state_d  = REPORT;
            enable_d = 1'b1;
          end
        end
      end
      REPORT: begin
        state_d = HOLD;
        hold_d  = 8'd0;
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) state_d = IDLE;
        else                     hold_d  = hold_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == PLAY);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= 8'd0;
      player_q <= 3'd0;
      score_q  <= 3'd0;
      count_q  <= 3'd0;
      enable_q <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      player_q <= player_d;
      score_q  <= score_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      active_q <= active_d;
      busy_q   <= busy_d;
    end
  end

  assign playerID     = player_q;
  assign newScore     = score_q;
  assign guess_count  = count_q;
  assign enable       = enable_q;
  assign round_active = active_q;
  assign busy         = busy_q;

endmodule
